// File: rtl/hdmi_tmds_encoder_pkg.sv
// Shared TMDS constants, period codes and 8b/10b helper functions.
package hdmi_tmds_encoder_pkg;

  typedef enum logic [1:0] {
    PER_CTL = 2'd0,
    PER_PRE = 2'd1,
    PER_GB  = 2'd2,
    PER_VID = 2'd3
  } period_e;

  localparam logic [9:0] CTL00    = 10'b1101010100;
  localparam logic [9:0] CTL01    = 10'b0010101011;
  localparam logic [9:0] CTL10    = 10'b0101010100;
  localparam logic [9:0] CTL11    = 10'b1010101011;
  localparam logic [9:0] GB_VID_0 = 10'b1011001100;
  localparam logic [9:0] GB_VID_1 = 10'b0100110011;
  localparam logic [9:0] GB_VID_2 = 10'b1011001100;

  function automatic logic [9:0] ctl_code(input logic [1:0] c);
    logic [9:0] code;
    case (c)
      2'b00:   code = CTL00;
      2'b01:   code = CTL01;
      2'b10:   code = CTL10;
      2'b11:   code = CTL11;
      default: code = CTL00;
    endcase
    return code;
  endfunction

  function automatic logic [9:0] guard_code(input int k);
    logic [9:0] code;
    case (k % 3)
      0:       code = GB_VID_0;
      1:       code = GB_VID_1;
      2:       code = GB_VID_2;
      default: code = GB_VID_0;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] ones8(input logic [7:0] b);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, b[i]};
    return n;
  endfunction

  // Minimise-transition stage: XNOR chain for byte-heavy inputs, bit 8 flags XOR.
  function automatic logic [8:0] tmds_qm(input logic [7:0] d);
    logic [3:0] n1;
    logic       xn;
    logic [8:0] q;
    n1   = ones8(d);
    xn   = (n1 > 4'd4) || ((n1 == 4'd4) && (d[0] == 1'b0));
    q    = 9'd0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~xn;
    return q;
  endfunction

endpackage

// File: rtl/hdmi_tmds_encoder_lane.sv
// One TMDS lane: registered minimise-transition stage, then DC balance / control / guard select.
module hdmi_tmds_encoder_lane
  import hdmi_tmds_encoder_pkg::*;
#(
  parameter logic [9:0] GUARD = GB_VID_0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  period_e    i_period,
  input  logic [1:0] i_ctl,
  input  logic [7:0] i_byte,
  output logic [9:0] o_sym
);

  logic [8:0]        r_qm;
  logic [3:0]        r_n1;
  period_e           r_period;
  logic [1:0]        r_ctl;
  logic signed [4:0] r_cnt;
  logic [8:0]        w_qm;
  logic signed [5:0] w_cnt;
  logic signed [5:0] w_diff;
  logic signed [5:0] w_cnt_nxt;
  logic [9:0]        w_sym;

  assign w_qm = tmds_qm(i_byte);

  // Stage 1: q_m, its ones count and the side-band period/control fields.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_qm     <= 9'd0;
      r_n1     <= 4'd0;
      r_period <= PER_CTL;
      r_ctl    <= 2'b00;
    end else begin
      r_qm     <= w_qm;
      r_n1     <= ones8(w_qm[7:0]);
      r_period <= i_period;
      r_ctl    <= i_ctl;
    end
  end

  // DC balance decision; w_diff is ones minus zeros of q_m[7:0].
  always_comb begin
    w_cnt  = {r_cnt[4], r_cnt};
    w_diff = $signed({1'b0, r_n1, 1'b0}) - 6'sd8;
    if ((r_cnt == 5'sd0) || (r_n1 == 4'd4)) begin
      w_sym     = {~r_qm[8], r_qm[8], (r_qm[8] ? r_qm[7:0] : ~r_qm[7:0])};
      w_cnt_nxt = r_qm[8] ? (w_cnt + w_diff) : (w_cnt - w_diff);
    end else if ((!r_cnt[4] && (r_n1 > 4'd4)) || (r_cnt[4] && (r_n1 < 4'd4))) begin
      w_sym     = {1'b1, r_qm[8], ~r_qm[7:0]};
      w_cnt_nxt = w_cnt - w_diff + (r_qm[8] ? 6'sd2 : 6'sd0);
    end else begin
      w_sym     = {1'b0, r_qm[8], r_qm[7:0]};
      w_cnt_nxt = w_cnt + w_diff - (r_qm[8] ? 6'sd0 : 6'sd2);
    end
  end

  // Stage 2: output symbol; any non-video period restarts disparity from zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sym <= CTL00;
      r_cnt <= 5'sd0;
    end else begin
      case (r_period)
        PER_VID: begin
          o_sym <= w_sym;
          r_cnt <= w_cnt_nxt[4:0];
        end
        PER_GB: begin
          o_sym <= GUARD;
          r_cnt <= 5'sd0;
        end
        default: begin
          o_sym <= ctl_code(r_ctl);
          r_cnt <= 5'sd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hdmi_tmds_encoder.sv
// Multi-lane TMDS encoder: lookahead delay line, period classifier, per-lane control muxing.
module hdmi_tmds_encoder
  import hdmi_tmds_encoder_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int HDMI_MODE = 1,
  parameter int LOOKAHEAD = 10
) (
  input  logic                 I_rgb_clk,
  input  logic                 I_rst,
  input  logic                 I_rgb_de,
  input  logic                 I_rgb_hs,
  input  logic                 I_rgb_vs,
  input  logic [NUM_CH*8-1:0]  I_data,
  output logic [NUM_CH*10-1:0] O_tmds,
  output logic                 O_de
);

  localparam int LA = (HDMI_MODE != 0) ? LOOKAHEAD : 0;
  localparam int DW = NUM_CH * 8 + 3;
  localparam int TW = (LA > 10) ? LA : 10;

  logic [TW:0]         w_de_tap;
  logic                w_d0_hs;
  logic                w_d0_vs;
  logic [NUM_CH*8-1:0] w_d0_data;
  logic                w_pre_any;
  period_e             w_period;
  logic                r_de_s1;

  if (LA > 0) begin : g_dl
    logic [DW-1:0] r_dl [0:LA-1];

    // Shift toward tap 0; the live input is the furthest lookahead tap.
    always_ff @(posedge I_rgb_clk or posedge I_rst) begin
      if (I_rst) begin
        for (int j = 0; j < LA; j++) r_dl[j] <= {DW{1'b0}};
      end else begin
        for (int j = 0; j < LA - 1; j++) r_dl[j] <= r_dl[j+1];
        r_dl[LA-1] <= {I_rgb_de, I_rgb_hs, I_rgb_vs, I_data};
      end
    end

    // Tap decode.
    always_comb begin
      w_de_tap = {(TW+1){1'b0}};
      for (int j = 0; j < LA; j++) w_de_tap[j] = r_dl[j][DW-1];
      w_de_tap[LA] = I_rgb_de;
      w_d0_hs      = r_dl[0][DW-2];
      w_d0_vs      = r_dl[0][DW-3];
      w_d0_data    = r_dl[0][NUM_CH*8-1:0];
    end
  end else begin : g_nodl
    // No lookahead: the output stage samples the live input.
    always_comb begin
      w_de_tap  = {{TW{1'b0}}, I_rgb_de};
      w_d0_hs   = I_rgb_hs;
      w_d0_vs   = I_rgb_vs;
      w_d0_data = I_data;
    end
  end

  // Period priority: video, then guard (de within 2), then preamble (de within 3..10).
  always_comb begin
    w_pre_any = |w_de_tap[10:3];
    if (w_de_tap[0]) begin
      w_period = PER_VID;
    end else if ((HDMI_MODE != 0) && (w_de_tap[1] || w_de_tap[2])) begin
      w_period = PER_GB;
    end else if ((HDMI_MODE != 0) && w_pre_any) begin
      w_period = PER_PRE;
    end else begin
      w_period = PER_CTL;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    logic [1:0] w_ctl;

    // Lane 0 carries sync; lane 1 signals the video preamble.
    always_comb begin
      if (k == 0) begin
        w_ctl = {w_d0_vs, w_d0_hs};
      end else if ((k == 1) && (w_period == PER_PRE)) begin
        w_ctl = 2'b01;
      end else begin
        w_ctl = 2'b00;
      end
    end

    hdmi_tmds_encoder_lane #(
      .GUARD (guard_code(k))
    ) u_lane (
      .i_clk    (I_rgb_clk),
      .i_rst    (I_rst),
      .i_period (w_period),
      .i_ctl    (w_ctl),
      .i_byte   (w_d0_data[8*k +: 8]),
      .o_sym    (O_tmds[10*k +: 10])
    );
  end

  // DE follows the same two pipeline stages as the lane encoders.
  always_ff @(posedge I_rgb_clk or posedge I_rst) begin
    if (I_rst) begin
      r_de_s1 <= 1'b0;
      O_de    <= 1'b0;
    end else begin
      r_de_s1 <= w_de_tap[0];
      O_de    <= r_de_s1;
    end
  end

endmodule
